// File: rtl/blackjack_pkg.sv
// Shared card, owner and arbiter-state types for the blackjack card-draw path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package blackjack_pkg;

    localparam int DECK_SIZE = 52;
    localparam int CARD_W    = 7;

    typedef struct packed {
        logic [1:0] suit;
        logic       rsvd;
        logic [3:0] rank;
    } card_t;

    typedef enum logic {
        OWN_PLAYER = 1'b0,
        OWN_DEALER = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        S_LOAD,
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } arb_state_e;

endpackage

// File: rtl/deal_arbiter_rr_arb2.sv
// Two-way round-robin pick between player and dealer hit requests.
// Latency: combinational grant; last_grant updates on the cycle the grant is taken.
// Backpressure: grant is only committed when take is high.
module rr_arb2
    import blackjack_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   p_req,
    input  logic   d_req,
    input  logic   take,
    output logic   gnt_vld,
    output owner_e gnt_own
);

    owner_e last_grant;

    always_comb begin
        gnt_vld = p_req | d_req;
        if (p_req && d_req)
            gnt_own = (last_grant == OWN_PLAYER) ? OWN_DEALER : OWN_PLAYER;
        else if (d_req)
            gnt_own = OWN_DEALER;
        else
            gnt_own = OWN_PLAYER;
    end

    // Reset to dealer so the player wins the very first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_grant <= OWN_DEALER;
        else if (take)
            last_grant <= gnt_own;
    end

endmodule

// File: rtl/deal_arbiter.sv
// Shares the card drawer between player and dealer: opening deal, round-robin hits, deck tracking.
// Latency: req sampled at edge n -> draw_req at n+1; draw_ready at edge m -> card valid at m+1.
// Backpressure: requests are level and held until served; a one-cycle bubble follows every card.
module deal_arbiter
    import blackjack_pkg::*;
#(
    parameter int DECK_SIZE = 52,
    parameter int CARD_W    = 7,
    parameter int CNT_W     = 6,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_done,
    input  logic              new_round,
    input  logic              p_req,
    input  logic              d_req,
    output logic              draw_req,
    input  logic              draw_ready,
    input  logic [CARD_W-1:0] draw_card,
    output logic [CARD_W-1:0] card_out,
    output logic              p_card_valid,
    output logic              d_card_valid,
    output logic              init_done,
    output logic              busy,
    output logic              deck_empty,
    output logic              req_drop,
    output logic              draw_err,
    output logic [CNT_W-1:0]  cards_dealt
);

    localparam int               TW       = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DECK_SIZE);
    localparam logic [CNT_W-1:0] DEAL_MAX = CNT_W'(DECK_SIZE - 4);
    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT - 2);

    arb_state_e    state;
    owner_e        owner;
    logic          opening;
    logic [1:0]    init_cnt;
    logic [TW-1:0] tcnt;
    logic          gnt_vld;
    owner_e        gnt_own;
    logic          bubble;
    logic          take;

    assign bubble   = p_card_valid | d_card_valid;
    assign take     = (state == S_IDLE) && !new_round && !bubble && gnt_vld && !deck_empty;
    assign draw_req = (state == S_ISSUE);
    assign busy     = (state == S_ISSUE) || (state == S_WAIT);

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .p_req   (p_req),
        .d_req   (d_req),
        .take    (take),
        .gnt_vld (gnt_vld),
        .gnt_own (gnt_own)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_LOAD;
            owner        <= OWN_PLAYER;
            opening      <= 1'b0;
            init_cnt     <= 2'd0;
            tcnt         <= '0;
            card_out     <= '0;
            p_card_valid <= 1'b0;
            d_card_valid <= 1'b0;
            init_done    <= 1'b0;
            deck_empty   <= 1'b0;
            req_drop     <= 1'b0;
            draw_err     <= 1'b0;
            cards_dealt  <= '0;
        end else begin
            p_card_valid <= 1'b0;
            d_card_valid <= 1'b0;
            init_done    <= 1'b0;
            req_drop     <= 1'b0;
            draw_err     <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (load_done)
                        state <= S_IDLE;
                end
                S_IDLE: begin
                    if (new_round) begin
                        if (cards_dealt <= DEAL_MAX) begin
                            opening  <= 1'b1;
                            init_cnt <= 2'd0;
                            owner    <= OWN_PLAYER;
                            state    <= S_ISSUE;
                        end else begin
                            req_drop <= 1'b1;
                        end
                    end else if (!bubble && gnt_vld) begin
                        if (deck_empty) begin
                            req_drop <= 1'b1;
                        end else begin
                            owner <= gnt_own;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    tcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (draw_ready) begin
                        card_out     <= draw_card;
                        p_card_valid <= (owner == OWN_PLAYER);
                        d_card_valid <= (owner == OWN_DEALER);
                        if (cards_dealt != FULL_CNT)
                            cards_dealt <= cards_dealt + 1'b1;
                        if (cards_dealt >= FULL_CNT - 1'b1)
                            deck_empty <= 1'b1;
                        if (opening && init_cnt != 2'd3) begin
                            init_cnt <= init_cnt + 1'b1;
                            owner    <= (owner == OWN_PLAYER) ? OWN_DEALER : OWN_PLAYER;
                            state    <= S_ISSUE;
                        end else begin
                            init_done <= opening;
                            opening   <= 1'b0;
                            state     <= S_IDLE;
                        end
                    // Counter reaches TIMEOUT-1 on this edge: give up on the drawer.
                    end else if (tcnt == TO_LAST) begin
                        draw_err <= 1'b1;
                        opening  <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_deal_arbiter.sv
// Bench for deal_arbiter: scripted drawer, scoreboard of expected (owner, card) pairs.
module tb_deal_arbiter;
    import blackjack_pkg::*;

    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst, load_done, new_round, p_req, d_req, draw_ready;
    logic [6:0] draw_card, card_out;
    logic       draw_req, p_card_valid, d_card_valid, init_done, busy;
    logic       deck_empty, req_drop, draw_err;
    logic [5:0] cards_dealt;

    int total = 0, bad = 0;
    int cyc = 0, draws = 0, n_valid = 0, inits = 0, drops = 0, errs = 0;
    int req_cyc = 0, rdy_cyc = -10, err_cyc = 0;
    bit drawer_on = 1'b1;
    int resp_delay = 2;
    int pend = 0;
    logic [7:0] exp_q[$];
    logic [6:0] card_q[$];

    deal_arbiter #(.DECK_SIZE(52), .CARD_W(7), .CNT_W(6), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_done    (load_done),
        .new_round    (new_round),
        .p_req        (p_req),
        .d_req        (d_req),
        .draw_req     (draw_req),
        .draw_ready   (draw_ready),
        .draw_card    (draw_card),
        .card_out     (card_out),
        .p_card_valid (p_card_valid),
        .d_card_valid (d_card_valid),
        .init_done    (init_done),
        .busy         (busy),
        .deck_empty   (deck_empty),
        .req_drop     (req_drop),
        .draw_err     (draw_err),
        .cards_dealt  (cards_dealt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [6:0] rnd_card();
        card_t c;
        c.suit = 2'($urandom_range(3));
        c.rsvd = 1'b0;
        c.rank = 4'($urandom_range(13, 1));
        return c;
    endfunction

    // Drawer model: answers each draw_req after resp_delay cycles with the next queued card.
    initial begin
        draw_ready = 1'b0;
        draw_card  = '0;
        forever begin
            @(negedge clk);
            draw_ready = 1'b0;
            if (!drawer_on) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    draw_ready = 1'b1;
                    if (card_q.size() > 0) draw_card = card_q.pop_front();
                    else draw_card = '0;
                    rdy_cyc = cyc;
                end
            end else if (draw_req) begin
                pend = resp_delay;
            end
        end
    end

    // Output monitor and scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (draw_req) begin draws++; req_cyc = cyc; end
            if (req_drop) drops++;
            if (draw_err) begin errs++; err_cyc = cyc; end
            if (init_done) begin
                inits++;
                chk("init_with_d", 32'(d_card_valid), 1);
            end
            if (p_card_valid || d_card_valid) begin
                n_valid++;
                chk("onehot_valid", 32'(p_card_valid & d_card_valid), 0);
                chk("ready_to_valid", cyc - rdy_cyc, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_card", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("owner", 32'(d_card_valid), 32'(e[7]));
                    chk("card", 32'(card_out), 32'(e[6:0]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        chk("leftover_exp", exp_q.size(), 0);
        rst = 1'b0; p_req = 1'b0; d_req = 1'b0; new_round = 1'b0; load_done = 1'b0;
        drawer_on = 1'b0;
        exp_q.delete();
        card_q.delete();
        step(); step();
        rst = 1'b1; drawer_on = 1'b1; resp_delay = 2;
        step();
    endtask

    task automatic load();
        load_done = 1'b1;
        step(); step();
    endtask

    task automatic wait_valid(input int target, input string tag);
        int i = 0;
        while (n_valid < target && i < 400) begin step(); i++; end
        chk(tag, 32'(n_valid >= target), 1);
    endtask

    task automatic hit(input bit dealer, input logic [6:0] card, input string tag);
        int t = n_valid + 1;
        card_q.push_back(card);
        exp_q.push_back({dealer, card});
        if (dealer) d_req = 1'b1; else p_req = 1'b1;
        wait_valid(t, tag);
        p_req = 1'b0; d_req = 1'b0;
        step();
    endtask

    task automatic deal(input logic [6:0] c0, input logic [6:0] c1,
                        input logic [6:0] c2, input logic [6:0] c3);
        int t = inits + 1;
        int i = 0;
        card_q.push_back(c0); exp_q.push_back({1'b0, c0});
        card_q.push_back(c1); exp_q.push_back({1'b1, c1});
        card_q.push_back(c2); exp_q.push_back({1'b0, c2});
        card_q.push_back(c3); exp_q.push_back({1'b1, c3});
        new_round = 1'b1;
        step();
        new_round = 1'b0;
        while (inits < t && i < 400) begin step(); i++; end
        chk("init_done_seen", 32'(inits >= t), 1);
        step();
    endtask

    initial begin
        int d0, k, v0, e0, i;
        rst = 1'b0; load_done = 1'b0; new_round = 1'b0; p_req = 1'b0; d_req = 1'b0;
        #1;
        chk("rst_draw_req", 32'(draw_req), 0);
        chk("rst_card_out", 32'(card_out), 0);
        chk("rst_valids", 32'({p_card_valid, d_card_valid}), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_deck_empty", 32'(deck_empty), 0);
        chk("rst_pulses", 32'({req_drop, draw_err}), 0);
        chk("rst_cards_dealt", 32'(cards_dealt), 0);
        step(); step();
        rst = 1'b1;
        step();

        // Load gating: request held before the loader finishes.
        p_req = 1'b1;
        card_q.push_back(7'h15);
        exp_q.push_back({1'b0, 7'h15});
        repeat (6) step();
        chk("no_draw_in_load", draws, 0);
        chk("no_drop_in_load", drops, 0);
        load_done = 1'b1;
        step();
        chk("draw_req_idle_entry", 32'(draw_req), 0);
        step();
        chk("draw_req_after_idle", 32'(draw_req), 1);
        chk("busy_on_issue", 32'(busy), 1);
        wait_valid(1, "load_hit_valid");
        p_req = 1'b0;
        step();
        chk("draws_after_load", draws, 1);
        chk("dealt_after_load", 32'(cards_dealt), 1);

        // Opening deal from a fresh deck.
        do_reset(); load();
        d0 = draws;
        deal(7'd7, 7'd3, 7'd10, 7'd2);
        chk("open_draws", draws - d0, 4);
        chk("open_dealt", 32'(cards_dealt), 4);

        // Contention: player first, then dealer wins the re-contended tie, then player.
        card_q.push_back(7'h21); exp_q.push_back({1'b0, 7'h21});
        card_q.push_back(7'h42); exp_q.push_back({1'b1, 7'h42});
        card_q.push_back(7'h63); exp_q.push_back({1'b0, 7'h63});
        v0 = n_valid;
        p_req = 1'b1; d_req = 1'b1;
        wait_valid(v0 + 1, "cont_first");
        p_req = 1'b0;
        step();
        p_req = 1'b1;
        wait_valid(v0 + 2, "cont_second");
        d_req = 1'b0;
        wait_valid(v0 + 3, "cont_third");
        p_req = 1'b0;
        step();
        chk("cont_dealt", 32'(cards_dealt), 7);

        // Exhaustion.
        do_reset(); load();
        for (int r = 0; r < 12; r++) deal(rnd_card(), rnd_card(), rnd_card(), rnd_card());
        chk("dealt_48", 32'(cards_dealt), 48);
        hit(1'b0, rnd_card(), "hit_49");
        hit(1'b1, rnd_card(), "hit_50");
        chk("dealt_50", 32'(cards_dealt), 50);
        d0 = draws; k = drops;
        new_round = 1'b1;
        step();
        new_round = 1'b0;
        step(); step();
        chk("short_round_drop", drops - k, 1);
        chk("short_round_nodraw", draws - d0, 0);
        hit(1'b0, rnd_card(), "hit_51");
        chk("not_empty_51", 32'(deck_empty), 0);
        hit(1'b1, rnd_card(), "hit_52");
        chk("deck_empty", 32'(deck_empty), 1);
        chk("dealt_52", 32'(cards_dealt), 52);
        d0 = draws; k = drops;
        p_req = 1'b1;
        repeat (5) step();
        p_req = 1'b0;
        step(); step();
        chk("empty_drop_each_cycle", drops - k, 5);
        chk("empty_no_draw", draws - d0, 0);

        // Drawer timeout.
        do_reset(); load();
        drawer_on = 1'b0;
        e0 = errs; d0 = draws;
        p_req = 1'b1;
        i = 0;
        while (errs == e0 && i < 200) begin step(); i++; end
        p_req = 1'b0;
        chk("err_seen", 32'(errs > e0), 1);
        chk("err_delay", err_cyc - req_cyc, TIMEOUT);
        step();
        chk("idle_after_err", 32'(busy), 0);
        chk("dealt_after_err", 32'(cards_dealt), 0);
        chk("single_draw_timeout", draws - d0, 1);

        // Reset while waiting on the drawer.
        do_reset(); load();
        resp_delay = 20;
        card_q.push_back(rnd_card());
        d0 = draws;
        p_req = 1'b1;
        i = 0;
        while (draws == d0 && i < 50) begin step(); i++; end
        step(); step();
        chk("busy_in_wait", 32'(busy), 1);
        rst = 1'b0; load_done = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_outputs", 32'({draw_req, p_card_valid, d_card_valid, init_done,
                                   req_drop, draw_err, deck_empty}), 0);
        chk("midrst_card", 32'(card_out), 0);
        drawer_on = 1'b0;
        card_q.delete();
        step();
        rst = 1'b1; drawer_on = 1'b1; resp_delay = 2;
        v0 = n_valid; d0 = draws;
        repeat (10) step();
        chk("no_valid_after_rst", n_valid - v0, 0);
        chk("load_holds_draws", draws - d0, 0);
        card_q.push_back(7'h2b); exp_q.push_back({1'b0, 7'h2b});
        load_done = 1'b1;
        wait_valid(v0 + 1, "post_rst_hit");
        p_req = 1'b0;
        step();
        chk("post_rst_dealt", 32'(cards_dealt), 1);
        chk("final_exp_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deal_arbiter.md
Name: deal_arbiter

Overview:
- Schedules and shares the single card-draw datapath (deck RAM plus random-index drawer) between the player and dealer hand controllers.
- Holds off all draws until the deck loader finishes.
- Runs the four-card opening deal (P, D, P, D) on each new round.
- Arbitrates later hit requests round-robin and routes each drawn card back to the requester.
- Tracks cards consumed and flags deck exhaustion.

Parameters:
- DECK_SIZE, 52, number of cards available per shuffle
- CARD_W, 7, card encoding width: [6:5] suit, [4] reserved, [3:0] rank value
- CNT_W, 6, width of cards_dealt counter; must hold DECK_SIZE
- TIMEOUT, 64, max cycles to wait for draw_ready before aborting a draw

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- load_done  in  1  deck loader finished; level
- new_round  in  1  one-cycle pulse, start opening deal
- p_req  in  1  player hit request; level, held until p_card_valid
- d_req  in  1  dealer hit request; level, held until d_card_valid
- draw_req  out  1  one-cycle pulse to drawer
- draw_ready  in  1  drawer card valid pulse
- draw_card  in  CARD_W  drawn card, valid with draw_ready
- card_out  out  CARD_W  registered card to hand controllers
- p_card_valid  out  1  one-cycle pulse, card_out belongs to player
- d_card_valid  out  1  one-cycle pulse, card_out belongs to dealer
- init_done  out  1  one-cycle pulse after fourth opening card
- busy  out  1  high in any state except S_LOAD/S_IDLE
- deck_empty  out  1  sticky, cards_dealt == DECK_SIZE
- req_drop  out  1  one-cycle pulse, request rejected
- draw_err  out  1  one-cycle pulse, drawer timeout
- cards_dealt  out  CNT_W  cards consumed since reset

Behaviour:
- Reset (rst=0, async): state=S_LOAD.
  - All outputs 0; card_out=0; cards_dealt=0.
  - last_grant=dealer (so player wins the first tie); init_cnt=0; timeout counter=0.
- S_LOAD: stay until load_done=1, then S_IDLE. Requests and new_round are ignored silently (no req_drop).
- S_IDLE priority:
  - No grant in a cycle where p_card_valid or d_card_valid is high. This one-cycle bubble lets the requester drop its req.
  - new_round=1 and (DECK_SIZE-cards_dealt)>=4: set opening mode, init_cnt=0, owner=player, go to S_ISSUE.
  - new_round=1 with fewer than 4 cards left: pulse req_drop, stay in S_IDLE.
  - Else, if either req is high and deck_empty=0: grant round-robin (if both are high, the one not equal to last_grant wins). Update last_grant, go to S_ISSUE.
  - Req high with deck_empty=1: req_drop pulses every cycle the req stays high. The requester must release it.
- S_ISSUE: draw_req=1 for exactly one cycle, clear timeout counter, go to S_WAIT.
- S_WAIT: wait for draw_ready.
  - On draw_ready: card_out<=draw_card, owner valid pulses next cycle, cards_dealt+1, deck_empty set when count reaches DECK_SIZE.
  - In opening mode with init_cnt<3: init_cnt+1, owner toggles, go to S_ISSUE.
  - At init_cnt=3: init_done pulses together with the fourth d_card_valid, go to S_IDLE.
  - Otherwise go to S_IDLE.
  - Timeout counter reaching TIMEOUT-1 without draw_ready: pulse draw_err, abort (opening mode also cleared), go to S_IDLE. Count is unchanged.
- Latency:
  - Req sampled at edge n gives draw_req high at n+1.
  - draw_ready at edge m gives card valid at m+1.
  - Opening deal needs 4 drawer round-trips.
- Opening-deal requests: p_req/d_req during the opening deal are held and served after init_done.
- new_round while busy: ignored, no req_drop.
- draw_ready outside S_WAIT: ignored.
- Counter: cards_dealt saturates at DECK_SIZE, never wraps.
- Reset mid-operation: immediately returns to S_LOAD; an in-flight card is discarded.

Decomposition:
- Shared package blackjack_pkg holds:
  - the card_t struct (suit, reserved, rank);
  - the DECK_SIZE and CARD_W constants;
  - owner_e (OWN_PLAYER, OWN_DEALER);
  - the arbiter state enum.
- Optional sub-module rr_arb2 (2-way round-robin with last_grant register). The FSM, counters and timeout stay in deal_arbiter.

Test Plan:
- Load gating: p_req=1 before load_done; load_done rises at t -> no draw_req until the cycle after S_IDLE is entered, then one draw_req.
- Opening deal: new_round pulse, drawer returns cards 7,3,10,2 -> exactly 4 draw_req pulses; valid order p,d,p,d; init_done pulses with the 4th card; cards_dealt=4.
- Contention: p_req and d_req high together in S_IDLE after reset -> player served first, then dealer; p_req reasserted with d_req -> dealer wins (round-robin).
- Exhaustion: deal 50 cards, then new_round -> req_drop pulse, no draw. Two more hits -> deck_empty=1, cards_dealt=52. Further p_req -> req_drop each cycle.
- Timeout: drawer never raises draw_ready -> draw_err pulse exactly TIMEOUT cycles after draw_req; state returns to idle; cards_dealt unchanged.
- Reset mid-draw: rst low while in S_WAIT -> all outputs 0 immediately; no card_valid after release; S_LOAD waits for load_done.
